// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment capture block: active-low hex glyphs
// (bit7 dp, bits 6..0 g..a), the blank pattern and the capture FSM states.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index is the nibble value; dp bit is held off (1) in every glyph.
  localparam logic [7:0] GLYPHS [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

endpackage

// File: rtl/sevenseg_pattern_match.sv
// Combinational inverse map from a 7-bit active-low segment pattern to a hex
// nibble; o_hit is low when the pattern is not one of the 16 glyphs.
module sevenseg_pattern_match
  import sevenseg_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_hit
);

  always_comb begin
    o_nibble = 4'h0;
    o_hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == GLYPHS[i][6:0]) begin
        o_nibble = 4'(i);
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Observes a multiplexed seven-segment bus and publishes a decoded frame once
// every digit has been seen stable. Macro SEVENSEG_CAPTURE_DP_EN enables dp capture.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_valid,
  output logic [1:0]            dbg_state
);

`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam logic [SEG_W-1:0]  SEG_IDLE = SEG_BLANK[SEG_W-1:0];
  localparam logic [7:0]        CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]        CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] ALL_SEEN = '1;

  logic [SEG_W-1:0]    r_seg_s1, r_seg_s2, r_prev_seg;
  logic [DIGITS-1:0]   r_an_s1, r_an_s2, r_prev_an;
  logic [7:0]          r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_sh_val, r_value;
  logic [DIGITS-1:0]   r_sh_err, r_err;
  logic                r_fv;
  state_t              r_state;

  logic                w_same, w_capture, w_full, w_hit;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_cap_mask, w_seen_n, w_sh_err_n;
  logic [4*DIGITS-1:0] w_sh_val_n;

`ifdef SEVENSEG_CAPTURE_DP_EN
  logic [DIGITS-1:0]   r_sh_dp, r_dp, w_sh_dp_n;
  assign dp_out = r_dp;
`else
  // dp is deliberately dropped before the synchroniser.
  logic w_unused_dp;
  assign w_unused_dp = seg_in[7];
  assign dp_out      = '0;
`endif

  sevenseg_pattern_match u_match (
    .i_pattern (r_seg_s2[6:0]),
    .o_nibble  (w_nib),
    .o_hit     (w_hit)
  );

  always_comb begin
    w_same     = (r_seg_s2 == r_prev_seg) && (r_an_s2 == r_prev_an) && $onehot(~r_an_s2);
    w_capture  = w_same && (r_cnt == CNT_LAST);
    w_cap_mask = w_capture ? ~r_an_s2 : '0;
    w_sh_val_n = r_sh_val;
    w_sh_err_n = r_sh_err;
`ifdef SEVENSEG_CAPTURE_DP_EN
    w_sh_dp_n  = r_sh_dp;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cap_mask[i]) begin
        w_sh_val_n[4*i +: 4] = w_hit ? w_nib : 4'h0;
        w_sh_err_n[i]        = ~w_hit;
`ifdef SEVENSEG_CAPTURE_DP_EN
        w_sh_dp_n[i]         = ~r_seg_s2[7];
`endif
      end
    end
    w_seen_n = r_seen | w_cap_mask;
    w_full   = (w_seen_n == ALL_SEEN);
  end

  // frame_valid is a bare one-cycle strobe (no ready): outputs change in the
  // same cycle it is high and hold until the next strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_s1   <= SEG_IDLE;
      r_seg_s2   <= SEG_IDLE;
      r_prev_seg <= SEG_IDLE;
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_prev_an  <= '1;
      r_cnt      <= '0;
      r_seen     <= '0;
      r_sh_val   <= '0;
      r_sh_err   <= '0;
      r_value    <= '0;
      r_err      <= '0;
      r_fv       <= 1'b0;
      r_state    <= ST_IDLE;
`ifdef SEVENSEG_CAPTURE_DP_EN
      r_sh_dp    <= '0;
      r_dp       <= '0;
`endif
    end else begin
      r_seg_s1   <= seg_in[SEG_W-1:0];
      r_seg_s2   <= r_seg_s1;
      r_an_s1    <= an_in;
      r_an_s2    <= r_an_s1;
      r_prev_seg <= r_seg_s2;
      r_prev_an  <= r_an_s2;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 8'd1;
      r_sh_val <= w_sh_val_n;
      r_sh_err <= w_sh_err_n;
`ifdef SEVENSEG_CAPTURE_DP_EN
      r_sh_dp  <= w_sh_dp_n;
`endif
      r_fv <= 1'b0;
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_full) begin
            // Publish includes the completing capture made on this same edge.
            r_state <= ST_PUBLISH;
            r_value <= w_sh_val_n;
            r_err   <= w_sh_err_n;
`ifdef SEVENSEG_CAPTURE_DP_EN
            r_dp    <= w_sh_dp_n;
`endif
            r_fv    <= 1'b1;
            r_seen  <= '0;
          end else begin
            r_seen <= w_seen_n;
            if (w_capture) r_state <= ST_COLLECT;
          end
        end
        ST_PUBLISH: begin
          r_seen  <= w_cap_mask;
          r_state <= ST_COLLECT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign value_out   = r_value;
  assign err_out     = r_err;
  assign frame_valid = r_fv;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: a stream-level model (run lengths of
// raw input samples) predicts every output each cycle, plus literal checks.
module tb_sevenseg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;
  localparam logic [7:0] GL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk, rst;
  logic [7:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value_out;
  logic [3:0]  dp_out, err_out;
  logic        frame_valid;
  logic [1:0]  dbg_state;

  sevenseg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .value_out   (value_out),
    .dp_out      (dp_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  int dut_frames = 0;
  int last_fv_edge = -1;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------- model ----------------
  // A digit is taken when its exact input sample has repeated STABLE+1 times;
  // the published frame shows up two edges later (synchroniser delay).
  logic [23:0] exp_q[$];
  int          exp_edge_q[$];
  logic [11:0] m_last;
  int          m_run;
  logic [3:0]  m_seen, m_dp, m_err;
  logic [15:0] m_val;
  logic [15:0] m_val_out;
  logic [3:0]  m_dp_out, m_err_out;
  logic        m_fv;

  always @(posedge clk) begin : model
    logic [11:0] key;
    logic [3:0]  sel, nib;
    logic        hit;
    edge_cnt++;
    if (rst) begin
      m_last = '1; m_run = 0; m_seen = '0; m_val = '0; m_dp = '0; m_err = '0;
      exp_q.delete(); exp_edge_q.delete();
      m_val_out = '0; m_dp_out = '0; m_err_out = '0; m_fv = 1'b0;
    end else begin
      m_fv = 1'b0;
      if (exp_edge_q.size() > 0 && exp_edge_q[0] == edge_cnt) begin
        {m_val_out, m_dp_out, m_err_out} = exp_q.pop_front();
        void'(exp_edge_q.pop_front());
        m_fv = 1'b1;
      end
`ifdef SEVENSEG_CAPTURE_DP_EN
      key = {seg_in, an_in};
`else
      key = {1'b1, seg_in[6:0], an_in};
`endif
      if (key == m_last) m_run++; else m_run = 1;
      m_last = key;
      sel = ~an_in;
      if ($countones(sel) == 1 && m_run == STABLE + 1) begin
        nib = 4'h0; hit = 1'b0;
        for (int g = 0; g < 16; g++)
          if (seg_in[6:0] == GL[g][6:0]) begin nib = 4'(g); hit = 1'b1; end
        for (int d = 0; d < DIGITS; d++) begin
          if (sel[d]) begin
            m_val[4*d +: 4] = nib;
            m_err[d]        = ~hit;
`ifdef SEVENSEG_CAPTURE_DP_EN
            m_dp[d]         = ~seg_in[7];
`else
            m_dp[d]         = 1'b0;
`endif
            m_seen[d]       = 1'b1;
          end
        end
        if (m_seen == 4'hF) begin
          exp_q.push_back({m_val, m_dp, m_err});
          exp_edge_q.push_back(edge_cnt + 2);
          m_seen = '0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
      check("cyc_value_out", {16'b0, value_out}, {16'b0, m_val_out});
      check("cyc_dp_out", {28'b0, dp_out}, {28'b0, m_dp_out});
      check("cyc_err_out", {28'b0, err_out}, {28'b0, m_err_out});
      if (frame_valid === 1'b1) begin
        dut_frames++;
        last_fv_edge = edge_cnt;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [7:0] seg, input logic [3:0] an, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seg_in = seg;
      an_in  = an;
    end
  endtask

  task automatic show(input int d, input logic [7:0] seg, input int n);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    drive(seg, an, n);
  endtask

  task automatic blank(input int n);
    drive(8'hFF, 4'hF, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; seg_in = 8'hFF; an_in = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    blank(3);
  endtask

  // ---------------- stimulus ----------------
  int f0, e0;
  logic [3:0] exp_dp;

  initial begin
    rst = 1'b1; seg_in = 8'hFF; an_in = 4'hF;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_value", {16'b0, value_out}, 32'h0);
    check("rst_dp", {28'b0, dp_out}, 32'h0);
    check("rst_err", {28'b0, err_out}, 32'h0);
    check("rst_fv", {31'b0, frame_valid}, 32'h0);
    rst = 1'b0;
    blank(3);

    // glyphs 1,2,3,4 on digits 0..3
    f0 = dut_frames;
    for (int d = 0; d < 4; d++) show(d, GL[d+1], 20);
    blank(5);
    check("t1_frames", dut_frames - f0, 1);
    check("t1_value", {16'b0, value_out}, 32'h4321);
    check("t1_err", {28'b0, err_out}, 32'h0);

    // unrecognised pattern on digit 2
    f0 = dut_frames;
    show(0, GL[5], 12); show(1, GL[5], 12); show(2, 8'b1111_1110, 12); show(3, GL[5], 12);
    blank(4);
    check("t2_frames", dut_frames - f0, 1);
    check("t2_value", {16'b0, value_out}, 32'h5055);
    check("t2_err", {28'b0, err_out}, 32'h4);

    // too short to be stable: nothing published, outputs hold
    f0 = dut_frames;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++) show(d, GL[7], 5);
    blank(4);
    check("t3_frames", dut_frames - f0, 0);
    check("t3_hold_value", {16'b0, value_out}, 32'h5055);

    // dp plus glyph 7 on digit 1
    f0 = dut_frames;
    show(0, GL[0], 12); show(1, 8'b0111_1000, 12); show(2, GL[0], 12); show(3, GL[0], 12);
    blank(4);
`ifdef SEVENSEG_CAPTURE_DP_EN
    exp_dp = 4'b0010;
`else
    exp_dp = 4'b0000;
`endif
    check("t4_frames", dut_frames - f0, 1);
    check("t4_value", {16'b0, value_out}, 32'h0070);
    check("t4_dp", {28'b0, dp_out}, {28'b0, exp_dp});

    // reset mid-frame discards digits 0..2
    pulse_reset();
    show(0, GL[9], 12); show(1, GL[9], 12); show(2, GL[9], 12);
    blank(2);
    pulse_reset();
    f0 = dut_frames;
    show(3, GL[8], 12);
    blank(3);
    check("t5_no_frame", dut_frames - f0, 0);
    check("t5_value_reset", {16'b0, value_out}, 32'h0);
    show(0, GL[10], 12); show(1, GL[11], 12); show(2, GL[12], 12);
    blank(4);
    check("t5_frames", dut_frames - f0, 1);
    check("t5_value", {16'b0, value_out}, 32'h8CBA);

    // blanking between digits, latency of the completing digit
    f0 = dut_frames;
    show(0, GL[13], 12); blank(3);
    show(1, GL[14], 12); blank(3);
    show(2, GL[15], 12); blank(3);
    @(negedge clk);
    e0 = edge_cnt + 1;
    seg_in = GL[6]; an_in = 4'b0111;
    show(3, GL[6], 11);
    blank(4);
    check("t6_frames", dut_frames - f0, 1);
    check("t6_value", {16'b0, value_out}, 32'h6FED);
    check("t6_latency", last_fv_edge + 1 - e0, 2 + STABLE + 1);

    // boundary: STABLE+1 samples capture, STABLE samples do not
    f0 = dut_frames;
    for (int d = 0; d < 4; d++) show(d, GL[1], STABLE + 1);
    blank(4);
    check("t7_frames", dut_frames - f0, 1);
    check("t7_value", {16'b0, value_out}, 32'h1111);
    f0 = dut_frames;
    for (int d = 0; d < 4; d++) show(d, GL[2], STABLE);
    blank(4);
    check("t8_frames", dut_frames - f0, 0);
    check("t8_value", {16'b0, value_out}, 32'h1111);

    // dp toggling every cycle: breaks stability only when dp is captured
    f0 = dut_frames;
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 12; i++) show(d, GL[3] ^ {i[0], 7'b0}, 1);
    blank(4);
`ifdef SEVENSEG_CAPTURE_DP_EN
    check("t9_frames", dut_frames - f0, 0);
    check("t9_value", {16'b0, value_out}, 32'h1111);
`else
    check("t9_frames", dut_frames - f0, 1);
    check("t9_value", {16'b0, value_out}, 32'h3333);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
